revive_instr_align: RTL and testbench

Fetch-side instruction aligner for the ReVive core. It accepts naturally aligned 32-bit words from the fetch bus interface, holds them in a four-halfword buffer, and extracts one instruction per handshake, whether 16-bit or 32-bit, including 32-bit instructions that straddle a word boundary. Each extracted instruction is expanded through `revive_instr_decompress` and presented to decode together with its PC. Jumps flush the buffer and retarget the PC, including halfword-aligned targets.

---
 rtl/revive_instr_align_pkg.sv | 27 ++
 rtl/revive_instr_align_decompress.sv | 98 +++++++++
 rtl/revive_instr_align.sv | 111 +++++++++++
 tb/tb_revive_instr_align.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/revive_instr_align_pkg.sv
// Shared types and RV32 base-ISA constants for the ReVive fetch aligner
// and its RVC expander.
package revive_instr_align_pkg;

  localparam int unsigned W_INSTR = 32;
  localparam int unsigned W_HWORD = 16;

  typedef logic [W_HWORD-1:0] hword_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [W_INSTR-1:0] INSTR_ILLEGAL = 32'h0000_0000;
  localparam logic [W_INSTR-1:0] INSTR_EBREAK  = 32'h0010_0073;

  // Compressed 3-bit register fields address x8..x15.
  function automatic logic [4:0] rvc_reg(input logic [2:0] r);
    return {2'b01, r};
  endfunction

endpackage

// File: rtl/revive_instr_align_decompress.sv
// RV32C to RV32I expander. Pure combinational; illegal or unsupported
// compressed encodings expand to all-zeros so decode traps on them.
module revive_instr_decompress
  import revive_instr_align_pkg::*;
#(
  parameter bit PASSTHROUGH = 1'b0
) (
  input  logic [W_INSTR-1:0] instr_i,
  output logic [W_INSTR-1:0] instr_o,
  output logic               is_32bit_o
);

  logic [15:0] c;
  assign c = instr_i[15:0];

  always_comb begin
    instr_o    = INSTR_ILLEGAL;
    is_32bit_o = 1'b0;
    if (PASSTHROUGH || (instr_i[1:0] == 2'b11)) begin
      instr_o    = instr_i;
      is_32bit_o = 1'b1;
    end else begin
      case (c[1:0])
        2'b00: begin
          case (c[15:13])
            3'b000: if ({c[10:7], c[12:11], c[5], c[6]} != 8'h00)
              instr_o = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rvc_reg(c[4:2]), OPC_OP_IMM};
            3'b010: instr_o = {5'b0, c[5], c[12:10], c[6], 2'b00, rvc_reg(c[9:7]), 3'b010, rvc_reg(c[4:2]), OPC_LOAD};
            3'b110: instr_o = {5'b0, c[5], c[12], rvc_reg(c[4:2]), rvc_reg(c[9:7]), 3'b010, c[11:10], c[6], 2'b00, OPC_STORE};
            default: ;
          endcase
        end
        2'b01: begin
          case (c[15:13])
            3'b000: instr_o = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], OPC_OP_IMM};
            3'b001: instr_o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}}, 5'd1, OPC_JAL};
            3'b010: instr_o = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, c[11:7], OPC_OP_IMM};
            3'b011: begin
              if (c[11:7] == 5'd2) begin
                if ({c[12], c[6:2]} != 6'h00)
                  instr_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
              end else if ({c[12], c[6:2]} != 6'h00) begin
                instr_o = {{14{c[12]}}, c[12], c[6:2], c[11:7], OPC_LUI};
              end
            end
            3'b100: begin
              case (c[11:10])
                2'b00: if (!c[12])
                  instr_o = {7'b0000000, c[6:2], rvc_reg(c[9:7]), 3'b101, rvc_reg(c[9:7]), OPC_OP_IMM};
                2'b01: if (!c[12])
                  instr_o = {7'b0100000, c[6:2], rvc_reg(c[9:7]), 3'b101, rvc_reg(c[9:7]), OPC_OP_IMM};
                2'b10: instr_o = {{6{c[12]}}, c[12], c[6:2], rvc_reg(c[9:7]), 3'b111, rvc_reg(c[9:7]), OPC_OP_IMM};
                default: begin
                  if (!c[12]) begin
                    case (c[6:5])
                      2'b00:   instr_o = {7'b0100000, rvc_reg(c[4:2]), rvc_reg(c[9:7]), 3'b000, rvc_reg(c[9:7]), OPC_OP};
                      2'b01:   instr_o = {7'b0000000, rvc_reg(c[4:2]), rvc_reg(c[9:7]), 3'b100, rvc_reg(c[9:7]), OPC_OP};
                      2'b10:   instr_o = {7'b0000000, rvc_reg(c[4:2]), rvc_reg(c[9:7]), 3'b110, rvc_reg(c[9:7]), OPC_OP};
                      default: instr_o = {7'b0000000, rvc_reg(c[4:2]), rvc_reg(c[9:7]), 3'b111, rvc_reg(c[9:7]), OPC_OP};
                    endcase
                  end
                end
              endcase
            end
            3'b101: instr_o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}}, 5'd0, OPC_JAL};
            default: // c.beqz / c.bnez, funct3 taken from c[13]
              instr_o = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rvc_reg(c[9:7]), {2'b00, c[13]}, c[11:10], c[4:3], c[12], OPC_BRANCH};
          endcase
        end
        2'b10: begin
          case (c[15:13])
            3'b000: if (!c[12])
              instr_o = {7'b0000000, c[6:2], c[11:7], 3'b001, c[11:7], OPC_OP_IMM};
            3'b010: if (c[11:7] != 5'd0)
              instr_o = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], OPC_LOAD};
            3'b100: begin
              if (!c[12]) begin
                if (c[6:2] == 5'd0) begin
                  if (c[11:7] != 5'd0) instr_o = {12'h000, c[11:7], 3'b000, 5'd0, OPC_JALR};
                end else begin
                  instr_o = {7'b0000000, c[6:2], 5'd0, 3'b000, c[11:7], OPC_OP};
                end
              end else if (c[6:2] == 5'd0) begin
                instr_o = (c[11:7] == 5'd0) ? INSTR_EBREAK : {12'h000, c[11:7], 3'b000, 5'd1, OPC_JALR};
              end else begin
                instr_o = {7'b0000000, c[6:2], c[11:7], 3'b000, c[11:7], OPC_OP};
              end
            end
            3'b110: instr_o = {4'b0000, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, OPC_STORE};
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/revive_instr_align.sv
// Fetch-side aligner: buffers fetched words as halfwords, hands one
// 16- or 32-bit instruction per handshake to decode, expanded and tagged with its PC.
module revive_instr_align
  import revive_instr_align_pkg::*;
#(
  parameter bit                PASSTHROUGH  = 1'b0,
  parameter int unsigned       W_ADDR       = 32,
  parameter logic [W_ADDR-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W_INSTR-1:0] fetch_data,
  input  logic               fetch_vld,
  output logic               fetch_rdy,
  input  logic               jump_vld,
  input  logic [W_ADDR-1:0]  jump_target,
  output logic [W_INSTR-1:0] instr,
  output logic               instr_is_32bit,
  output logic [W_ADDR-1:0]  instr_pc,
  output logic               instr_vld,
  input  logic               instr_rdy
);

  localparam int unsigned N_SLOTS = 4;
  localparam int unsigned W_LEVEL = 3;

  hword_t             slots_q [N_SLOTS];
  hword_t             slots_d [N_SLOTS];
  logic [W_LEVEL-1:0] level_q, level_d;
  logic [W_LEVEL-1:0] need, lvl_shift;
  logic [W_ADDR-1:0]  pc_q, pc_d;
  logic               discard_hw_q, discard_hw_d;
  logic               head_32, consume, accept;

  // Head length and handshakes, derived from registered state only.
  always_comb begin
    head_32   = PASSTHROUGH || (slots_q[0][1:0] == 2'b11);
    need      = head_32 ? W_LEVEL'(2) : W_LEVEL'(1);
    instr_vld = (level_q >= need);
    fetch_rdy = (level_q <= W_LEVEL'(2));
    consume   = instr_vld && instr_rdy;
    accept    = fetch_vld && fetch_rdy;
  end

  // Shift out the consumed head first, then append the accepted word behind it.
  always_comb begin
    slots_d      = slots_q;
    level_d      = level_q;
    pc_d         = pc_q;
    discard_hw_d = discard_hw_q;
    lvl_shift    = level_q;
    if (consume) begin
      lvl_shift = level_q - need;
      pc_d      = pc_q + (head_32 ? W_ADDR'(4) : W_ADDR'(2));
      if (head_32) begin
        slots_d[0] = slots_q[2];
        slots_d[1] = slots_q[3];
      end else begin
        slots_d[0] = slots_q[1];
        slots_d[1] = slots_q[2];
        slots_d[2] = slots_q[3];
      end
    end
    level_d = lvl_shift;
    if (accept) begin
      if (discard_hw_q) begin
        slots_d[lvl_shift[1:0]] = fetch_data[31:16];
        level_d                 = lvl_shift + W_LEVEL'(1);
        discard_hw_d            = 1'b0;
      end else begin
        slots_d[lvl_shift[1:0]]         = fetch_data[15:0];
        slots_d[lvl_shift[1:0] + 2'd1]  = fetch_data[31:16];
        level_d                         = lvl_shift + W_LEVEL'(2);
      end
    end
    // Redirect drops the whole buffer; the slot contents become stale.
    if (jump_vld) begin
      level_d      = '0;
      pc_d         = jump_target & ~W_ADDR'(1);
      discard_hw_d = jump_target[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q      <= '0;
      pc_q         <= RESET_VECTOR;
      discard_hw_q <= 1'b0;
    end else begin
      level_q      <= level_d;
      pc_q         <= pc_d;
      discard_hw_q <= discard_hw_d;
    end
  end

  // Slots above level are don't-care, so the buffer itself is never reset.
  always_ff @(posedge clk) begin
    slots_q <= slots_d;
  end

  assign instr_pc = pc_q;

  revive_instr_decompress #(
    .PASSTHROUGH (PASSTHROUGH)
  ) u_decompress (
    .instr_i    ({slots_q[1], slots_q[0]}),
    .instr_o    (instr),
    .is_32bit_o (instr_is_32bit)
  );

endmodule

// File: tb/tb_revive_instr_align.sv
// Directed bench for revive_instr_align: RVC and passthrough instances
// share stimulus; each scenario task checks its own expected values.
module tb_revive_instr_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_data;
  logic        fetch_vld;
  logic        jump_vld;
  logic [31:0] jump_target;
  logic        instr_rdy;

  logic        fetch_rdy, instr_is_32bit, instr_vld;
  logic [31:0] instr, instr_pc;
  logic        pt_fetch_rdy, pt_is_32bit, pt_vld;
  logic [31:0] pt_instr, pt_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  revive_instr_align #(.PASSTHROUGH(1'b0), .W_ADDR(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_data(fetch_data), .fetch_vld(fetch_vld),
    .fetch_rdy(fetch_rdy), .jump_vld(jump_vld), .jump_target(jump_target),
    .instr(instr), .instr_is_32bit(instr_is_32bit), .instr_pc(instr_pc),
    .instr_vld(instr_vld), .instr_rdy(instr_rdy)
  );

  revive_instr_align #(.PASSTHROUGH(1'b1), .W_ADDR(32), .RESET_VECTOR(32'h0)) dut_pt (
    .clk(clk), .rst_n(rst_n), .fetch_data(fetch_data), .fetch_vld(fetch_vld),
    .fetch_rdy(pt_fetch_rdy), .jump_vld(jump_vld), .jump_target(jump_target),
    .instr(pt_instr), .instr_is_32bit(pt_is_32bit), .instr_pc(pt_pc),
    .instr_vld(pt_vld), .instr_rdy(instr_rdy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_data  = 32'h0;
    fetch_vld   = 1'b0;
    jump_vld    = 1'b0;
    jump_target = 32'h0;
    instr_rdy   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n       = 1'b0;
    jump_vld    = 1'b1;
    jump_target = 32'h80;
    fetch_vld   = 1'b1;
    fetch_data  = 32'h00500093;
    instr_rdy   = 1'b1;
    step();
    step();
    idle_inputs();
    rst_n = 1'b1;
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", instr_vld); end
    checks++; if (fetch_rdy !== 1'b1) begin errors++; $display("FAIL reset_fetch_rdy got %b want 1", fetch_rdy); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", instr_pc); end
    checks++; if (pt_vld !== 1'b0) begin errors++; $display("FAIL reset_pt_vld got %b want 0", pt_vld); end
    checks++; if (pt_fetch_rdy !== 1'b1) begin errors++; $display("FAIL reset_pt_fetch_rdy got %b want 1", pt_fetch_rdy); end
  endtask

  task automatic test_aligned32();
    do_reset();
    instr_rdy  = 1'b1;
    fetch_vld  = 1'b1;
    fetch_data = 32'h00500093;
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL al_pre_vld got %b want 0", instr_vld); end
    step();
    fetch_data = 32'h00a00113;
    checks++; if (instr_vld !== 1'b1) begin errors++; $display("FAIL al0_vld got %b want 1", instr_vld); end
    checks++; if (instr !== 32'h00500093) begin errors++; $display("FAIL al0_instr got %h want 00500093", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL al0_pc got %h want 00000000", instr_pc); end
    checks++; if (instr_is_32bit !== 1'b1) begin errors++; $display("FAIL al0_is32 got %b want 1", instr_is_32bit); end
    step();
    fetch_vld = 1'b0;
    checks++; if (instr !== 32'h00a00113) begin errors++; $display("FAIL al1_instr got %h want 00a00113", instr); end
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL al1_pc got %h want 00000004", instr_pc); end
    step();
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL al_drain_vld got %b want 0", instr_vld); end
    checks++; if (instr_pc !== 32'h8) begin errors++; $display("FAIL al_drain_pc got %h want 00000008", instr_pc); end
  endtask

  task automatic test_compressed_pair();
    do_reset();
    instr_rdy  = 1'b1;
    fetch_vld  = 1'b1;
    fetch_data = 32'h46054505;
    step();
    fetch_vld = 1'b0;
    checks++; if (instr !== 32'h00100513) begin errors++; $display("FAIL cp0_instr got %h want 00100513", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL cp0_pc got %h want 00000000", instr_pc); end
    checks++; if (instr_is_32bit !== 1'b0) begin errors++; $display("FAIL cp0_is32 got %b want 0", instr_is_32bit); end
    step();
    checks++; if (instr_vld !== 1'b1) begin errors++; $display("FAIL cp1_vld got %b want 1", instr_vld); end
    checks++; if (instr !== 32'h00100613) begin errors++; $display("FAIL cp1_instr got %h want 00100613", instr); end
    checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL cp1_pc got %h want 00000002", instr_pc); end
    checks++; if (instr_is_32bit !== 1'b0) begin errors++; $display("FAIL cp1_is32 got %b want 0", instr_is_32bit); end
    step();
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL cp_drain_vld got %b want 0", instr_vld); end
  endtask

  task automatic test_illegal_zero();
    do_reset();
    instr_rdy  = 1'b1;
    fetch_vld  = 1'b1;
    fetch_data = 32'h45050000;
    step();
    fetch_vld = 1'b0;
    checks++; if (instr_vld !== 1'b1) begin errors++; $display("FAIL iz_vld got %b want 1", instr_vld); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL iz_instr got %h want 00000000", instr); end
    checks++; if (instr_is_32bit !== 1'b0) begin errors++; $display("FAIL iz_is32 got %b want 0", instr_is_32bit); end
    step();
    checks++; if (instr !== 32'h00100513) begin errors++; $display("FAIL iz_next_instr got %h want 00100513", instr); end
    checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL iz_next_pc got %h want 00000002", instr_pc); end
  endtask

  task automatic test_straddle();
    do_reset();
    instr_rdy  = 1'b1;
    fetch_vld  = 1'b1;
    fetch_data = 32'h00934505;
    step();
    fetch_vld = 1'b0;
    checks++; if (instr !== 32'h00100513) begin errors++; $display("FAIL st0_instr got %h want 00100513", instr); end
    step();
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL st_half_vld got %b want 0", instr_vld); end
    checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL st_half_pc got %h want 00000002", instr_pc); end
    fetch_vld  = 1'b1;
    fetch_data = 32'hABCD0050;
    step();
    fetch_vld = 1'b0;
    checks++; if (instr_vld !== 1'b1) begin errors++; $display("FAIL st1_vld got %b want 1", instr_vld); end
    checks++; if (instr !== 32'h00500093) begin errors++; $display("FAIL st1_instr got %h want 00500093", instr); end
    checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL st1_pc got %h want 00000002", instr_pc); end
    checks++; if (instr_is_32bit !== 1'b1) begin errors++; $display("FAIL st1_is32 got %b want 1", instr_is_32bit); end
    checks++; if (fetch_rdy !== 1'b0) begin errors++; $display("FAIL st_level3_rdy got %b want 0", fetch_rdy); end
  endtask

  task automatic test_halfword_jump();
    do_reset();
    instr_rdy   = 1'b1;
    jump_vld    = 1'b1;
    jump_target = 32'h103;
    step();
    jump_vld = 1'b0;
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL hj_vld got %b want 0", instr_vld); end
    checks++; if (instr_pc !== 32'h102) begin errors++; $display("FAIL hj_pc got %h want 00000102", instr_pc); end
    fetch_vld  = 1'b1;
    fetch_data = 32'h4505FFFF;
    step();
    fetch_vld = 1'b0;
    checks++; if (instr !== 32'h00100513) begin errors++; $display("FAIL hj_instr got %h want 00100513", instr); end
    checks++; if (instr_pc !== 32'h102) begin errors++; $display("FAIL hj_instr_pc got %h want 00000102", instr_pc); end
    checks++; if (instr_vld !== 1'b1) begin errors++; $display("FAIL hj_instr_vld got %b want 1", instr_vld); end
    step();
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL hj_empty_vld got %b want 0", instr_vld); end
    checks++; if (fetch_rdy !== 1'b1) begin errors++; $display("FAIL hj_empty_rdy got %b want 1", fetch_rdy); end
    checks++; if (instr_pc !== 32'h104) begin errors++; $display("FAIL hj_empty_pc got %h want 00000104", instr_pc); end
  endtask

  task automatic test_backpressure_jump();
    do_reset();
    jump_vld    = 1'b1;
    jump_target = 32'h2;
    step();
    jump_vld   = 1'b0;
    fetch_vld  = 1'b1;
    fetch_data = 32'h46054505;
    step();
    fetch_data = 32'h45054505;
    checks++; if (instr !== 32'h00100613) begin errors++; $display("FAIL bp0_instr got %h want 00100613", instr); end
    checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL bp0_pc got %h want 00000002", instr_pc); end
    checks++; if (fetch_rdy !== 1'b1) begin errors++; $display("FAIL bp0_rdy got %b want 1", fetch_rdy); end
    step();
    checks++; if (fetch_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_rdy got %b want 0", fetch_rdy); end
    checks++; if (instr_pc !== 32'h2) begin errors++; $display("FAIL bp_held_pc got %h want 00000002", instr_pc); end
    instr_rdy = 1'b1;
    step();
    checks++; if (fetch_rdy !== 1'b1) begin errors++; $display("FAIL bp_drain_rdy got %b want 1", fetch_rdy); end
    checks++; if (instr !== 32'h00100513) begin errors++; $display("FAIL bp1_instr got %h want 00100513", instr); end
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL bp1_pc got %h want 00000004", instr_pc); end
    jump_vld    = 1'b1;
    jump_target = 32'h200;
    fetch_data  = 32'h00500093;
    step();
    jump_vld  = 1'b0;
    fetch_vld = 1'b0;
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL bj_vld got %b want 0", instr_vld); end
    checks++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL bj_pc got %h want 00000200", instr_pc); end
    checks++; if (fetch_rdy !== 1'b1) begin errors++; $display("FAIL bj_rdy got %b want 1", fetch_rdy); end
    step();
    checks++; if (instr_vld !== 1'b0) begin errors++; $display("FAIL bj_stale_vld got %b want 0", instr_vld); end
    fetch_vld  = 1'b1;
    fetch_data = 32'h00a00113;
    step();
    fetch_vld = 1'b0;
    checks++; if (instr !== 32'h00a00113) begin errors++; $display("FAIL bj_new_instr got %h want 00a00113", instr); end
    checks++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL bj_new_pc got %h want 00000200", instr_pc); end
  endtask

  task automatic test_passthrough();
    do_reset();
    instr_rdy  = 1'b1;
    fetch_vld  = 1'b1;
    fetch_data = 32'h45054505;
    step();
    fetch_vld = 1'b0;
    checks++; if (pt_vld !== 1'b1) begin errors++; $display("FAIL pt_vld got %b want 1", pt_vld); end
    checks++; if (pt_instr !== 32'h45054505) begin errors++; $display("FAIL pt_instr got %h want 45054505", pt_instr); end
    checks++; if (pt_is_32bit !== 1'b1) begin errors++; $display("FAIL pt_is32 got %b want 1", pt_is_32bit); end
    checks++; if (pt_pc !== 32'h0) begin errors++; $display("FAIL pt_pc got %h want 00000000", pt_pc); end
    step();
    checks++; if (pt_vld !== 1'b0) begin errors++; $display("FAIL pt_drain_vld got %b want 0", pt_vld); end
    checks++; if (pt_pc !== 32'h4) begin errors++; $display("FAIL pt_next_pc got %h want 00000004", pt_pc); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_aligned32();
    test_compressed_pair();
    test_illegal_zero();
    test_straddle();
    test_halfword_jump();
    test_backpressure_jump();
    test_passthrough();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
